// File: rtl/sram_port_pkg.sv
// Shared types and constants for the SRAM port master and its response FIFO.
package sram_port_pkg;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   localparam int unsigned READ_LATENCY = 2;
   localparam int unsigned FIFO_DEPTH   = 2;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small in-order response FIFO with valid/ready output and synchronous active-low reset.
// The producer guarantees a free slot before pushing, so there is no push back-pressure.
module sram_rsp_fifo
   import sram_port_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                                 clk,
   input  logic                                 rstb,
   input  logic                                 push,
   input  logic [DATA_WIDTH-1:0]                push_data,
   input  logic                                 pop_ready,
   output logic                                 pop_valid,
   output logic [DATA_WIDTH-1:0]                pop_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      count
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  pop;

   assign pop_valid = (count != '0);
   assign pop       = pop_valid && pop_ready;
   assign pop_data  = mem[rd_ptr];

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_port_master.sv
// Initiator for a single-port RW OpenRAM macro: turns a valid/ready request stream into
// registered macro cycles, returns read data in order, and optionally clears the array after reset.
module sram_port_master
   import sram_port_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter int unsigned           ADDR_WIDTH = 4,
   parameter int unsigned           RAM_DEPTH  = 1 << ADDR_WIDTH,
   parameter bit                    INIT_CLEAR = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk0,
   input  logic                  rstb0,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic                  csb0,
   output logic                  web0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);

   localparam int unsigned IFW = $clog2(READ_LATENCY + 1);
   localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   init_ptr;
   logic [READ_LATENCY-1:0] rd_pipe;
   logic [IFW-1:0]          inflight;
   logic [FCW-1:0]          fifo_count;
   logic                    accept;
   logic                    accept_rd;
   logic                    push;

   // Reads still travelling through the macro each reserve a FIFO slot.
   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + IFW'(rd_pipe[i]);
      end
   end

   assign req_ready = init_done && ((32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH);
   assign accept    = req_valid && req_ready;
   assign accept_rd = accept && (req_we == OP_READ);
   // dout0 is valid at the posedge READ_LATENCY cycles after acceptance.
   assign push      = rd_pipe[READ_LATENCY-1];

   // Control FSM with registered macro pins; reset discards reads still in the pipe.
   always_ff @(posedge clk0) begin
      if (!rstb0) begin
         state     <= INIT_CLEAR ? INIT : RUN;
         init_ptr  <= '0;
         init_done <= 1'b0;
         csb0      <= 1'b1;
         web0      <= 1'b1;
         addr0     <= '0;
         din0      <= '0;
         rd_pipe   <= '0;
      end else begin
         rd_pipe <= {rd_pipe[READ_LATENCY-2:0], accept_rd};
         case (state)
            INIT: begin
               csb0  <= 1'b0;
               web0  <= 1'b0;
               addr0 <= init_ptr;
               din0  <= INIT_VALUE;
               if (init_ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                  state <= RUN;
               end else begin
                  init_ptr <= init_ptr + ADDR_WIDTH'(1);
               end
            end
            RUN: begin
               init_done <= 1'b1;
               if (accept) begin
                  csb0  <= 1'b0;
                  web0  <= (req_we == OP_WRITE) ? 1'b0 : 1'b1;
                  addr0 <= req_addr;
                  din0  <= req_wdata;
               end else begin
                  csb0 <= 1'b1;
                  web0 <= 1'b1;
               end
            end
         endcase
      end
   end

   sram_rsp_fifo #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_rsp_fifo (
      .clk       (clk0),
      .rstb      (rstb0),
      .push      (push),
      .push_data (dout0),
      .pop_ready (rsp_ready),
      .pop_valid (rsp_valid),
      .pop_data  (rsp_rdata),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_sram_port_master.sv
// Self-checking bench for sram_port_master with a behavioural OpenRAM-style macro model.
module tb_sram_port_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: INIT_CLEAR = 1, INIT_VALUE = A5
   logic       a_rstb, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
   logic       a_init_done, a_csb, a_web;
   logic [3:0] a_req_addr, a_addr;
   logic [7:0] a_req_wdata, a_rsp_rdata, a_din, a_dout;

   // Instance B: INIT_CLEAR = 0
   logic       b_rstb, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
   logic       b_init_done, b_csb, b_web;
   logic [3:0] b_req_addr, b_addr;
   logic [7:0] b_req_wdata, b_rsp_rdata, b_din, b_dout;

   sram_port_master #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(16), .INIT_CLEAR(1'b1), .INIT_VALUE(8'hA5)
   ) dut_a (
      .clk0(clk), .rstb0(a_rstb), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
      .init_done(a_init_done), .csb0(a_csb), .web0(a_web), .addr0(a_addr),
      .din0(a_din), .dout0(a_dout)
   );

   sram_port_master #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(16), .INIT_CLEAR(1'b0), .INIT_VALUE(8'h00)
   ) dut_b (
      .clk0(clk), .rstb0(b_rstb), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
      .init_done(b_init_done), .csb0(b_csb), .web0(b_web), .addr0(b_addr),
      .din0(b_din), .dout0(b_dout)
   );

   // Macro models: pins captured at posedge, array access on the following negedge,
   // read data appears a short delay later and holds until the next read.
   logic [7:0] mem_a [16];
   logic       a_cs_q, a_we_q;
   logic [3:0] a_ad_q;
   logic [7:0] a_di_q;
   int         macro_ops_a = 0;

   always @(posedge clk) begin
      a_cs_q <= a_csb; a_we_q <= a_web; a_ad_q <= a_addr; a_di_q <= a_din;
      if (!a_csb) macro_ops_a <= macro_ops_a + 1;
   end
   always @(negedge clk) begin
      if (!a_cs_q) begin
         if (!a_we_q) mem_a[a_ad_q] <= a_di_q;
         else         a_dout <= #2 mem_a[a_ad_q];
      end
   end

   logic [7:0] mem_b [16];
   logic       b_cs_q, b_we_q;
   logic [3:0] b_ad_q;
   logic [7:0] b_di_q;

   always @(posedge clk) begin
      b_cs_q <= b_csb; b_we_q <= b_web; b_ad_q <= b_addr; b_di_q <= b_din;
   end
   always @(negedge clk) begin
      if (!b_cs_q) begin
         if (!b_we_q) mem_b[b_ad_q] <= b_di_q;
         else         b_dout <= #2 mem_b[b_ad_q];
      end
   end

   // Scoreboard state
   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q [$];
   logic       acc;
   logic [7:0] cur_exp;

   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } vec_t;
   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // One clock: monitor handshakes at negedge, then return #1 after the posedge.
   task automatic cycle();
      @(negedge clk);
      if (!a_rstb) begin
         exp_q.delete();
      end else begin
         if (a_req_valid && a_req_ready) begin
            acc = 1'b1;
            if (!a_req_we) exp_q.push_back(cur_exp);
         end
         if (a_rsp_valid && a_rsp_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_rsp: got data %h with no outstanding read", a_rsp_rdata);
            end else begin
               check("rsp_data", a_rsp_rdata, exp_q.pop_front());
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input string name);
      for (int k = 0; k < 40 && !acc; k++) cycle();
      check(name, acc, 1);
   endtask

   task automatic issue(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp);
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
      cur_exp = exp; acc = 1'b0;
      wait_acc("req_accept");
      a_req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) cycle();
      check("drain_empty", exp_q.size(), 0);
   endtask

   // Called right after rstb is released: expects the full clear sweep, then RUN.
   task automatic check_sweep();
      for (int i = 0; i < 16; i++) begin
         cycle();
         check("init_sweep",
               {a_csb, a_web, a_addr, a_din, a_init_done, a_req_ready, a_rsp_valid},
               {1'b0, 1'b0, 4'(i), 8'hA5, 3'b000});
      end
      cycle();
      check("init_done_rise", {a_init_done, a_req_ready, a_csb, a_web}, 4'b1111);
   endtask

   initial begin
      int ops0;
      vecs = '{
         '{1'b1, 4'd0,  8'h11, 8'h00},
         '{1'b1, 4'd1,  8'h22, 8'h00},
         '{1'b1, 4'd2,  8'h33, 8'h00},
         '{1'b0, 4'd7,  8'h00, 8'hA5},
         '{1'b0, 4'd0,  8'h00, 8'h11},
         '{1'b1, 4'd9,  8'hC3, 8'h00},
         '{1'b0, 4'd9,  8'h00, 8'hC3},
         '{1'b0, 4'd1,  8'h00, 8'h22},
         '{1'b0, 4'd15, 8'h00, 8'hA5},
         '{1'b1, 4'd15, 8'h0F, 8'h00},
         '{1'b0, 4'd15, 8'h00, 8'h0F},
         '{1'b0, 4'd2,  8'h00, 8'h33},
         '{1'b1, 4'd4,  8'h5A, 8'h00},
         '{1'b0, 4'd4,  8'h00, 8'h5A}
      };
      a_rstb = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
      a_rsp_ready = 1'b1; acc = 1'b0; cur_exp = '0;
      b_rstb = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
      b_rsp_ready = 1'b1;

      // Reset state
      repeat (3) cycle();
      check("reset_state", {a_csb, a_web, a_addr, a_din, a_req_ready, a_rsp_valid, a_init_done},
            {1'b1, 1'b1, 4'h0, 8'h00, 3'b000});

      // Clear sweep after reset
      a_rstb = 1'b1;
      check_sweep();

      // Table-driven traffic
      for (int i = 0; i < 14; i++) begin
         issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
      end
      drain();

      // Write then read same address: 2-cycle read latency, new data returned
      issue(1'b1, 4'd3, 8'h5C, 8'h00);
      issue(1'b0, 4'd3, 8'h00, 8'h5C);
      check("lat_n0_valid", a_rsp_valid, 0);
      cycle();
      check("lat_n1_valid", a_rsp_valid, 0);
      cycle();
      check("lat_n2_valid", a_rsp_valid, 1);
      check("lat_n2_data", a_rsp_rdata, 8'h5C);
      drain();

      // Back-pressure: third read held while two are outstanding
      a_rsp_ready = 1'b0;
      issue(1'b0, 4'd0, 8'h00, 8'h11);
      issue(1'b0, 4'd1, 8'h00, 8'h22);
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 4'd2; cur_exp = 8'h33; acc = 1'b0;
      repeat (4) cycle();
      check("bp_held", {acc, a_req_ready}, 2'b00);
      check("bp_rsp_valid", a_rsp_valid, 1);
      check("bp_head_stable", a_rsp_rdata, 8'h11);
      a_rsp_ready = 1'b1;
      wait_acc("bp_accept");
      a_req_valid = 1'b0;
      drain();

      // Idle cycles: pins inactive and no macro accesses
      ops0 = macro_ops_a;
      repeat (5) begin
         cycle();
         check("idle_pins", {a_csb, a_web}, 2'b11);
      end
      check("idle_macro_ops", macro_ops_a - ops0, 0);

      // Reset one cycle after a read is accepted: read discarded, sweep restarts
      issue(1'b0, 4'd5, 8'h00, 8'hA5);
      a_rstb = 1'b0;
      cycle();
      check("midrst_pins", {a_csb, a_rsp_valid, a_init_done}, 3'b100);
      a_rstb = 1'b1;
      check_sweep();
      repeat (3) cycle();
      check("midrst_no_rsp", a_rsp_valid, 0);

      // INIT_CLEAR = 0 instance
      b_rstb = 1'b1;
      cycle();
      check("b_ready_after_rst", {b_init_done, b_req_ready}, 2'b11);
      b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 4'd15; b_req_wdata = 8'hF0;
      cycle();
      check("b_write_pins", {b_csb, b_web, b_addr, b_din}, {1'b0, 1'b0, 4'hF, 8'hF0});
      b_req_we = 1'b0;
      cycle();
      b_req_valid = 1'b0;
      check("b_read_pins", {b_csb, b_web, b_addr}, {1'b0, 1'b1, 4'hF});
      cycle();
      cycle();
      check("b_rsp_valid", b_rsp_valid, 1);
      check("b_rsp_data", b_rsp_rdata, 8'hF0);
      cycle();
      check("b_rsp_popped", b_rsp_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sram_port_master.md
Name: sram_port_master

Overview:
- Initiator for the single-port RW OpenRAM macro interface (csb0/web0/addr0/din0/dout0), instantiated beside each RAM_Mem-style macro.
- Converts a valid/ready request stream into correctly timed macro cycles and returns read data on a valid/ready response stream.
- After reset, optionally clears the whole array before accepting traffic.

Parameters:
- DATA_WIDTH, 8, word width; must match the macro.
- ADDR_WIDTH, 4, address width; must match the macro.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words cleared by the init sweep.
- INIT_CLEAR, 1, 1 = write INIT_VALUE to every word after reset; 0 = skip the sweep.
- INIT_VALUE, 0, DATA_WIDTH fill value for the init sweep.

Ports:
- clk0  in  1  clock; same clock as the macro's clk0.
- rstb0  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at posedge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  read data present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at posedge.
- rsp_rdata  out  DATA_WIDTH  read data, in request order.
- init_done  out  1  high once the init sweep is finished (or skipped).
- csb0  out  1  macro chip select, active low.
- web0  out  1  macro write enable, active low.
- addr0  out  ADDR_WIDTH  macro address.
- din0  out  DATA_WIDTH  macro write data.
- dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset (clk0 posedge with rstb0 = 0):
  - csb0 = 1, web0 = 1, addr0 = 0, din0 = 0.
  - req_ready = 0, rsp_valid = 0, init_done = 0.
  - Response buffer emptied; the in-flight read flag is cleared.
- Mid-operation reset: any in-flight read is discarded and its response is never produced; the FSM re-enters INIT.
- Macro outputs (csb0/web0/addr0/din0) are registers updated at posedge with nonblocking assignment. The macro samples them at the following posedge.
- FSM states:
  - INIT (entered from reset when INIT_CLEAR = 1):
    - Each cycle drives csb0 = 0, web0 = 0, addr0 = init_ptr, din0 = INIT_VALUE.
    - init_ptr runs 0 .. RAM_DEPTH-1.
    - After the write at RAM_DEPTH-1 is issued, go to RUN.
  - RUN:
    - init_done = 1.
    - Requests are serviced.
    - With INIT_CLEAR = 0, reset goes straight to RUN.
    - RUN is terminal until the next reset.
- Timing in RUN:
  - Request accepted at posedge N → csb0/web0/addr0/din0 driven from N, captured by the macro at N+1.
  - With no acceptance at N, csb0 = 1 and web0 = 1 from N.
  - Read: dout0 is sampled at posedge N+2 into the response buffer, so rsp_valid rises after N+2 (2-cycle latency).
  - Sampling at N+2 is the required point: dout0 settles DELAY after the negedge of cycle N+1 and holds until T_HOLD after posedge N+2.
  - Write: produces no response.
- Throughput: back-to-back acceptance, one request per cycle. A read immediately after a write to the same address returns the new data, since the macro writes on the negedge before the read.
- Response buffer: 2-entry FIFO, in-order.
  - req_ready = init_done && (fifo_count + inflight_read) < 2 for reads.
  - Writes are also gated by init_done only, but are held off while a read would overflow. Simplest compliant rule: apply the same gate to all requests.
  - FIFO push and pop in the same cycle: count unchanged.
  - rsp_rdata is stable while rsp_valid && !rsp_ready.
- req_ready is 0 throughout INIT; requests presented then are held, not dropped.
- Address wrap: none; addresses ≥ RAM_DEPTH are passed through unchanged.

Decomposition:
- Package sram_port_pkg:
  - state enum {INIT, RUN}.
  - Localparams for the read latency (2) and FIFO depth (2).
  - Op encoding constants (OP_READ = 0, OP_WRITE = 1).
- Sub-module sram_rsp_fifo: 2-entry synchronous FIFO with valid/ready and sync active-low reset.

Test Plan:
- Reset with INIT_CLEAR = 1, INIT_VALUE = 8'hA5:
  - 16 consecutive macro writes, addr0 0..15, csb0 = web0 = 0, din0 = A5.
  - init_done rises on the cycle after the addr 15 write is issued.
  - Reading addr 7 then returns A5.
- Write addr 3 = 8'h5C, then read addr 3 on the next cycle:
  - rsp_valid asserts 2 cycles after the read's acceptance, rsp_rdata = 5C.
- Reads of addr 0, 1, 2 back-to-back with rsp_ready = 0:
  - Two reads are accepted, req_ready drops.
  - Releasing rsp_ready yields the data in order with no loss.
- INIT_CLEAR = 0:
  - init_done = 1 and req_ready = 1 one cycle after reset release.
  - Writing F0 to addr 15 and reading it back returns F0.
- rstb0 pulsed low one cycle after a read is accepted:
  - No rsp_valid ever appears for that read.
  - csb0 = 1 on the reset cycle, and the init sweep restarts at addr0 = 0.
- Idle cycles in RUN: csb0 = 1, web0 = 1, and the macro performs no reads or writes.
